// File: rtl/video_gt_framer.sv
// Transmit framer: pixel stream -> 16-bit 8b10b word stream with IDLE/SOF/EOF/CC K-words.
// Optional clock-correction insertion is built when FRAMER_CC_EN is defined.
module video_gt_framer #(
  parameter int unsigned FIFO_DEPTH = 16,
  parameter int unsigned CC_PERIOD  = 1024,
  parameter int unsigned CC_LEN     = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        vs_in,
  input  logic        data_valid_in,
  input  logic [15:0] data_in,
  input  logic        tx_ready,
  output logic [15:0] tx_data,
  output logic [1:0]  tx_charisk,
  output logic        fifo_overflow,
  output logic [15:0] frame_cnt
);
  localparam int unsigned AW = $clog2(FIFO_DEPTH);
  localparam int unsigned EW = 19;
  localparam logic [15:0] W_IDLE = 16'h50BC;
  localparam logic [15:0] W_SOF  = 16'hFBBC;
  localparam logic [15:0] W_EOF  = 16'hFDBC;
  localparam logic [15:0] W_CC   = 16'h1C1C;

  typedef enum logic [2:0] {S_IDLE, S_SOF, S_DATA, S_EOF, S_CC} state_t;

  logic          vs_q, vs_d, vs_prev_q, vs_prev_d, pix_vld_q, pix_vld_d, sof_pend_q, sof_pend_d;
  logic [15:0]   pix_q, pix_d;
  logic [EW-1:0] mem_q [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [AW:0]   cnt_q, cnt_d;
  logic [17:0]   hold_q, hold_d;
  state_t        state_q, state_d, head_state;
  logic [15:0]   tx_data_q, tx_data_d, frame_cnt_q, frame_cnt_d;
  logic [1:0]    tx_k_q, tx_k_d;
  logic          ovf_q, ovf_d;
  logic          rise, fall, wr_req, wr_ok, pop, fifo_empty, fifo_full, advance;
  logic [EW-1:0] wr_entry, head;

`ifdef FRAMER_CC_EN
  localparam int unsigned CW = $clog2(CC_PERIOD);
  localparam int unsigned IW = $clog2(CC_LEN + 1);
  logic [CW-1:0] cc_cnt_q, cc_cnt_d;
  logic [IW-1:0] cc_idx_q, cc_idx_d;
  logic          cc_req_q, cc_req_d;
  state_t        cc_ret_q, cc_ret_d;
`else
  logic unused_cc_c;
  assign unused_cc_c = (CC_PERIOD == CC_LEN);
`endif

  assign fifo_empty = (cnt_q == '0);
  assign fifo_full  = (cnt_q == (AW+1)'(FIFO_DEPTH));
  assign head       = mem_q[rd_ptr_q];
  assign head_state = head[18] ? S_SOF : (head[16] ? S_DATA : S_EOF);

  always_comb begin
    // input stage and frame-marker tagging
    vs_d       = vs_in;
    vs_prev_d  = vs_q;
    pix_vld_d  = data_valid_in;
    pix_d      = data_in;
    rise       = vs_q & ~vs_prev_q;
    fall       = ~vs_q & vs_prev_q;
    wr_req     = pix_vld_q | fall;
    wr_entry   = {sof_pend_q | rise, fall, pix_vld_q, pix_vld_q ? pix_q : 16'h0000};
    sof_pend_d = wr_req ? 1'b0 : (rise | sof_pend_q);

    state_d     = state_q;
    hold_d      = hold_q;
    tx_data_d   = W_IDLE;
    tx_k_d      = 2'b01;
    frame_cnt_d = frame_cnt_q;
    pop         = 1'b0;
    advance     = 1'b0;
`ifdef FRAMER_CC_EN
    cc_cnt_d = cc_cnt_q;
    cc_idx_d = cc_idx_q;
    cc_req_d = cc_req_q;
    cc_ret_d = cc_ret_q;
`endif

    if (!tx_ready) begin
`ifdef FRAMER_CC_EN
      // an interrupted CC sequence is abandoned; the held word resumes later
      if (state_q == S_CC) begin
        state_d  = cc_ret_q;
        cc_idx_d = '0;
      end
`endif
    end
`ifdef FRAMER_CC_EN
    else if (cc_req_q && state_q != S_CC) begin
      tx_data_d = W_CC;
      tx_k_d    = 2'b11;
      cc_req_d  = 1'b0;
      if (CC_LEN > 1) begin
        cc_ret_d = state_q;
        state_d  = S_CC;
        cc_idx_d = IW'(1);
      end
    end
`endif
    else begin
      unique case (state_q)
        S_IDLE: advance = 1'b1;
        S_SOF: begin
          tx_data_d   = W_SOF;
          tx_k_d      = 2'b11;
          frame_cnt_d = frame_cnt_q + 16'd1;
          state_d     = hold_q[16] ? S_DATA : S_EOF;
        end
        S_DATA: begin
          tx_data_d = hold_q[15:0];
          tx_k_d    = 2'b00;
          if (hold_q[17]) state_d = S_EOF;
          else            advance = 1'b1;
        end
        S_EOF: begin
          tx_data_d = W_EOF;
          tx_k_d    = 2'b11;
          advance   = 1'b1;
        end
        default: begin
`ifdef FRAMER_CC_EN
          tx_data_d = W_CC;
          tx_k_d    = 2'b11;
          if (cc_idx_q == IW'(CC_LEN - 1)) begin
            state_d  = cc_ret_q;
            cc_idx_d = '0;
          end else begin
            cc_idx_d = cc_idx_q + IW'(1);
          end
`else
          state_d = S_IDLE;
`endif
        end
      endcase
      if (advance) begin
        if (!fifo_empty) begin
          pop     = 1'b1;
          hold_d  = head[17:0];
          state_d = head_state;
        end else begin
          state_d = S_IDLE;
        end
      end
    end

`ifdef FRAMER_CC_EN
    // free-running request timer, held at zero while the link is down
    if (!tx_ready) begin
      cc_cnt_d = '0;
      cc_req_d = 1'b0;
    end else if (cc_cnt_q == CW'(CC_PERIOD - 1)) begin
      cc_cnt_d = '0;
      cc_req_d = 1'b1;
    end else begin
      cc_cnt_d = cc_cnt_q + CW'(1);
    end
`endif

    wr_ok    = wr_req & (~fifo_full | pop);
    ovf_d    = ovf_q | (wr_req & ~wr_ok);
    wr_ptr_d = wr_ok ? wr_ptr_q + AW'(1) : wr_ptr_q;
    rd_ptr_d = pop ? rd_ptr_q + AW'(1) : rd_ptr_q;
    cnt_d    = cnt_q + (AW+1)'(wr_ok) - (AW+1)'(pop);
  end

  always_ff @(posedge clk) begin
    if (wr_ok) mem_q[wr_ptr_q] <= wr_entry;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      // sampling vs_in during reset prevents a false rising edge on release
      vs_q        <= vs_in;
      vs_prev_q   <= vs_in;
      pix_vld_q   <= 1'b0;
      pix_q       <= '0;
      sof_pend_q  <= 1'b0;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      cnt_q       <= '0;
      hold_q      <= '0;
      state_q     <= S_IDLE;
      tx_data_q   <= W_IDLE;
      tx_k_q      <= 2'b01;
      frame_cnt_q <= '0;
      ovf_q       <= 1'b0;
`ifdef FRAMER_CC_EN
      cc_cnt_q <= '0;
      cc_idx_q <= '0;
      cc_req_q <= 1'b0;
      cc_ret_q <= S_IDLE;
`endif
    end else begin
      vs_q        <= vs_d;
      vs_prev_q   <= vs_prev_d;
      pix_vld_q   <= pix_vld_d;
      pix_q       <= pix_d;
      sof_pend_q  <= sof_pend_d;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      cnt_q       <= cnt_d;
      hold_q      <= hold_d;
      state_q     <= state_d;
      tx_data_q   <= tx_data_d;
      tx_k_q      <= tx_k_d;
      frame_cnt_q <= frame_cnt_d;
      ovf_q       <= ovf_d;
`ifdef FRAMER_CC_EN
      cc_cnt_q <= cc_cnt_d;
      cc_idx_q <= cc_idx_d;
      cc_req_q <= cc_req_d;
      cc_ret_q <= cc_ret_d;
`endif
    end
  end

  assign tx_data       = tx_data_q;
  assign tx_charisk    = tx_k_q;
  assign fifo_overflow = ovf_q;
  assign frame_cnt     = frame_cnt_q;
endmodule

// File: tb/tb_video_gt_framer.sv
// Scoreboard bench for video_gt_framer: stimulus pushes expected words, a monitor pops and compares.
module tb_video_gt_framer;
  logic        clk = 1'b0;
  logic        rst_n, vs_in, data_valid_in, tx_ready;
  logic [15:0] data_in, tx_data, frame_cnt;
  logic [1:0]  tx_charisk;
  logic        fifo_overflow;

  int   n_vec = 0;
  int   n_err = 0;
  int   cc_seen = 0;
  int   exp_frames = 0;
  logic mon_en = 1'b0;
  logic rdy_s = 1'b1;
  logic [17:0] exp_q[$];

  localparam logic [17:0] E_SOF = {2'b11, 16'hFBBC};
  localparam logic [17:0] E_EOF = {2'b11, 16'hFDBC};

  video_gt_framer #(.FIFO_DEPTH(4), .CC_PERIOD(16), .CC_LEN(2)) dut (
    .clk(clk), .rst_n(rst_n), .vs_in(vs_in), .data_valid_in(data_valid_in),
    .data_in(data_in), .tx_ready(tx_ready), .tx_data(tx_data),
    .tx_charisk(tx_charisk), .fifo_overflow(fifo_overflow), .frame_cnt(frame_cnt)
  );

  always #5 clk = ~clk;
  always @(posedge clk) rdy_s <= tx_ready;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
    n_vec++;
    if (got !== want) begin
      n_err++;
      $display("FAIL %s: got %0h want %0h", name, got, want);
    end
  endtask

  // monitor: ignores IDLE (and CC when built), compares every other word against the queue
  always @(negedge clk) begin
    if (mon_en) begin
      logic [17:0] w;
      w = {tx_charisk, tx_data};
      if (!rdy_s) begin
        check("idle_while_not_ready", 32'(w), 32'({2'b01, 16'h50BC}));
      end else if (w == {2'b01, 16'h50BC}) begin
      end
`ifdef FRAMER_CC_EN
      else if (w == {2'b11, 16'h1C1C}) cc_seen++;
`endif
      else if (exp_q.size() == 0) begin
        n_vec++;
        n_err++;
        $display("FAIL unexpected_word: got %05h want none", w);
      end else begin
        check("stream_word", 32'(w), 32'(exp_q.pop_front()));
      end
    end
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic send_frame(input int n, input logic [15:0] base, input int gap, input int keep);
    exp_q.push_back(E_SOF);
    vs_in = 1'b1;
    if (n == 0) cyc();
    for (int i = 0; i < n; i++) begin
      data_valid_in = 1'b1;
      data_in = base + 16'(i);
      if (i < keep) exp_q.push_back({2'b00, base + 16'(i)});
      cyc();
      data_valid_in = 1'b0;
      repeat (gap) cyc();
    end
    vs_in = 1'b0;
    if (keep >= n) exp_q.push_back(E_EOF);
    cyc();
  endtask

  task automatic drain(input string name);
    repeat (20) cyc();
    check({name, "_queue_left"}, 32'(exp_q.size()), 32'd0);
    check({name, "_frame_cnt"}, 32'(frame_cnt), 32'(exp_frames));
  endtask

  initial begin
    logic is_cc [64];
    int ncc, cc0;
    rst_n = 1'b0; vs_in = 1'b0; data_valid_in = 1'b0; data_in = '0; tx_ready = 1'b1;
    repeat (3) cyc();
    check("reset_tx_data", 32'(tx_data), 32'h50BC);
    check("reset_charisk", 32'(tx_charisk), 32'd1);
    check("reset_overflow", 32'(fifo_overflow), 32'd0);
    check("reset_frame_cnt", 32'(frame_cnt), 32'd0);
    rst_n = 1'b1;
    mon_en = 1'b1;

    repeat (10) cyc();
    check("idle_frame_cnt", 32'(frame_cnt), 32'd0);
    check("idle_overflow", 32'(fifo_overflow), 32'd0);

    send_frame(4, 16'h0001, 0, 4);
    exp_frames++;
    drain("frame4");

    send_frame(0, 16'h0000, 0, 0);
    exp_frames++;
    drain("empty_frame");

    // continuous idle: CC pattern must repeat every 16 words, two words each
    ncc = 0;
    for (int i = 0; i < 64; i++) begin
      @(negedge clk);
      is_cc[i] = (tx_data == 16'h1C1C) && (tx_charisk == 2'b11);
      if (is_cc[i]) ncc++;
    end
`ifdef FRAMER_CC_EN
    check("cc_count_64", 32'(ncc), 32'd8);
    for (int i = 0; i < 48; i++)
      if (is_cc[i] != is_cc[i+16]) check("cc_period", 32'(i), 32'hFFFF_FFFF);
`else
    check("cc_count_64", 32'(ncc), 32'd0);
`endif

    cyc();
    cc0 = cc_seen;
    send_frame(12, 16'hA000, 1, 12);
    exp_frames++;
    drain("cc_burst");
`ifdef FRAMER_CC_EN
    check("cc_in_burst", 32'(cc_seen - cc0 >= 2), 32'd1);
`endif

    // overflow: depth 4, link down, 6 pixels -> only the first 4 survive, EOF dropped
    tx_ready = 1'b0;
    cyc();
    send_frame(6, 16'h0010, 0, 4);
    exp_frames++;
    repeat (5) cyc();
    check("overflow_set", 32'(fifo_overflow), 32'd1);
    check("overflow_out_idle", 32'(tx_data), 32'h50BC);
    tx_ready = 1'b1;
    drain("overflow");
    check("overflow_sticky", 32'(fifo_overflow), 32'd1);

    // reset mid-frame with FIFO holding pixels
    tx_ready = 1'b0;
    cyc();
    vs_in = 1'b1;
    for (int i = 0; i < 2; i++) begin
      data_valid_in = 1'b1;
      data_in = 16'h0BAD + 16'(i);
      cyc();
    end
    data_valid_in = 1'b0;
    repeat (2) cyc();
    rst_n = 1'b0;
    cyc();
    check("midreset_tx_data", 32'(tx_data), 32'h50BC);
    check("midreset_charisk", 32'(tx_charisk), 32'd1);
    check("midreset_overflow", 32'(fifo_overflow), 32'd0);
    check("midreset_frame_cnt", 32'(frame_cnt), 32'd0);
    rst_n = 1'b1;
    tx_ready = 1'b1;
    exp_frames = 0;
    repeat (12) cyc();
    exp_q.push_back(E_EOF);
    vs_in = 1'b0;
    cyc();
    drain("after_reset");

    mon_en = 1'b0;
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule

// File: doc/video_gt_framer.md
# video_gt_framer

Transmit-side framer between the video source (vs_in / data_valid_in / data_in[15:0]) and the GT transmitter user port of sfp_8b10b_top. It converts the pixel stream into a continuous 16-bit 8b10b word stream with K-character control:
- idle/comma words
- start-of-frame (SOF) and end-of-frame (EOF) markers
- periodic clock-correction (CC) sequences

A small FIFO absorbs the slots consumed by inserted control words.

## Interface
Parameters:
- FIFO_DEPTH, 16, entries in the elastic FIFO; power of two, ≥4
- CC_PERIOD, 1024, clocks between CC sequence requests; ≥ CC_LEN+4
- CC_LEN, 2, consecutive CC words per sequence; ≥1

Ports:
- clk  in  1  single clock for the whole block (GT TX user clock)
- rst_n  in  1  reset; synchronous, active-low
- vs_in  in  1  frame sync; high for the active frame
- data_valid_in  in  1  pixel strobe
- data_in  in  16  pixel
- tx_ready  in  1  GT TX reset done and link usable
- tx_data  out  16  word to GT; byte 0 = bits [7:0], transmitted first
- tx_charisk  out  2  K flag per byte
- fifo_overflow  out  1  sticky overflow flag
- frame_cnt  out  16  number of SOF markers sent; wraps at 0xFFFF→0

## Operation
Word codes (all others are data, charisk 00):
- IDLE: 0x50BC, charisk 01 (K28.5 + D16.2)
- SOF: 0xFBBC, charisk 11 (K28.5 + K27.7)
- EOF: 0xFDBC, charisk 11 (K28.5 + K29.7)
- CC: 0x1C1C, charisk 11 (K28.0 ×2)

Input stage:
- vs_in is registered; edges are detected against the previous sample.
- Each FIFO entry is {sof, eof, has_data, data[15:0]}, 19 bits.
- Rising edge of vs: sets sof_pending. The next pixel is written with sof=1, which clears sof_pending. A pixel in the same cycle as the rising edge is that first pixel.
- Pixel (data_valid_in=1): written with has_data=1 and sof=sof_pending. If vs falls in the same cycle, the pixel is written with eof=1.
- Falling edge of vs with no pixel: one entry written with has_data=0, eof=1, sof=sof_pending. This yields SOF then EOF for an empty frame. sof_pending is cleared.
- data_valid_in while vs_in is low is accepted as ordinary data.
- At most one FIFO write per cycle.

Overflow:
- A write to a full FIFO is discarded and fifo_overflow is set.
- fifo_overflow clears only on reset.

Output FSM:
- States: IDLE, SOF, DATA, EOF, CC. One word is registered out per cycle.
- IDLE: sends IDLE while the FIFO is empty or tx_ready=0. On a non-empty FIFO with tx_ready=1, pops the head into a hold register and goes to SOF if sof, else DATA if has_data, else EOF.
- SOF: sends SOF and increments frame_cnt. Next state is DATA if has_data, else EOF.
- DATA: sends the data word. Next state is EOF if eof; otherwise it pops the next entry (as IDLE does), or goes to IDLE if the FIFO is empty.
- EOF: sends EOF, then proceeds as at the end of DATA.
- CC: sends CC_LEN CC words, then resumes the interrupted transition.
- CC request: when the CC counter reaches CC_PERIOD-1, a request latches and the counter restarts. CC takes priority at the next word boundary, i.e. before any IDLE, SOF, DATA or EOF word is sent. It may split SOF from its pixel; the receiver strips CC.
- tx_ready=0:
  - output is forced to IDLE and the FIFO does not pop
  - an SOF/DATA/EOF in progress is held and re-sent in full once tx_ready returns
  - the CC counter is held at 0 and a pending CC request is cleared
  - FIFO writes continue

## Timing
- Reset values:
  - tx_data=0x50BC, tx_charisk=01
  - fifo_overflow=0, frame_cnt=0
  - FIFO empty, sof_pending=0, FSM IDLE, CC counter 0
- Reset in mid-frame discards FIFO contents. The next frame needs a fresh vs rising edge.
- Latency: a pixel sampled at edge t with the FIFO empty, FSM in IDLE, no SOF and no CC pending appears on tx_data after edge t+3. SOF adds 1 cycle; a CC sequence adds CC_LEN cycles.
- Throughput: one word per cycle. Sustained input must leave room for SOF, EOF and CC slots.
- Simultaneous read and write on a full FIFO: the write succeeds and no overflow is flagged.

## Configuration
- FRAMER_CC_EN defined: CC counter and CC state are present, as above.
- FRAMER_CC_EN undefined: no CC logic. CC words are never emitted and CC_PERIOD/CC_LEN are ignored. Latency is otherwise identical.

## Test plan
- Reset with tx_ready=1, no input → tx_data=0x50BC / charisk 01 every cycle; frame_cnt=0; fifo_overflow=0.
- vs_in rises, 4 pixels 0x0001..0x0004 on consecutive cycles, then vs_in falls → stream IDLE…, SOF 0xFBBC/11, 0x0001..0x0004/00, EOF 0xFDBC/11, IDLE; frame_cnt=1.
- vs_in pulse with no pixels → SOF immediately followed by EOF; frame_cnt=1.
- FRAMER_CC_EN, CC_PERIOD=16, continuous IDLE → every 16 cycles exactly 2 words of 0x1C1C/11. Pixel burst across a CC request → CC words inserted and no pixel lost or reordered.
- FIFO_DEPTH=4, tx_ready=0, write 6 pixels → fifo_overflow=1 and output IDLE. Raise tx_ready → first 4 pixels out in order.
- Assert rst_n=0 for 1 cycle in mid-frame → outputs return to reset values the next cycle and the FIFO is empty.
